twos_to_signmag_serial: RTL and testbench

Bit-serial decoder that converts a WIDTH-bit two's-complement word into sign-magnitude form. It is the reverse direction of the team's combinational two's-complement generator. It uses the classic LSB-first "copy through first 1, then invert" FSM, one bit per clock. It has valid/ready handshakes on both sides and sits between an arithmetic stage and sign-magnitude consumers (display/log formatting, magnitude comparators).

---
 rtl/twos_to_signmag_serial.sv | 128 ++++++++++++
 tb/tb_twos_to_signmag_serial.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/twos_to_signmag_serial.sv
// ============================================================================
// Module   : twos_to_signmag_serial
// Brief    : LSB-first bit-serial two's-complement to sign-magnitude decoder
//            ("copy through first 1, then invert"), valid/ready on both sides.
//            Optional macro TWOS_MIN_FLAG_EN adds out_min (most-negative flag).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module twos_to_signmag_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag
`ifdef TWOS_MIN_FLAG_EN
    ,
    output logic             out_min
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;
    logic             sign;
    logic             found_one;

    logic             bit_in;
    logic             bit_out;
    logic [WIDTH-1:0] work_next;

`ifdef TWOS_MIN_FLAG_EN
    localparam logic [WIDTH-1:0] MIN_WORD = {1'b1, {(WIDTH-1){1'b0}}};
    logic             min_word;
`endif

    // Once the first 1 of a negative word has passed, every later bit is inverted.
    always_comb begin
        bit_in    = shreg[0];
        bit_out   = (sign && found_one) ? ~bit_in : bit_in;
        work_next = {bit_out, work[WIDTH-1:1]};
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            work      <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            found_one <= 1'b0;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_mag   <= '0;
`ifdef TWOS_MIN_FLAG_EN
            min_word  <= 1'b0;
            out_min   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg     <= in_data;
                        sign      <= in_data[WIDTH-1];
                        cnt       <= '0;
                        found_one <= 1'b0;
                        work      <= '0;
`ifdef TWOS_MIN_FLAG_EN
                        min_word  <= (in_data == MIN_WORD);
`endif
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                    work  <= work_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (sign && !found_one) begin
                        found_one <= bit_in;
                    end
                    if (cnt == CNT_LAST) begin
                        out_mag   <= work_next;
                        out_sign  <= sign;
                        out_valid <= 1'b1;
`ifdef TWOS_MIN_FLAG_EN
                        out_min   <= min_word;
`endif
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // Result stays on the outputs after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_twos_to_signmag_serial.sv
// ============================================================================
// Module   : tb_twos_to_signmag_serial
// Brief    : Self-checking bench for twos_to_signmag_serial (WIDTH=4),
//            randomized words and backpressure against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twos_to_signmag_serial;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;
`ifdef TWOS_MIN_FLAG_EN
    logic         out_min;
`endif

    int n_vec;
    int n_err;

    twos_to_signmag_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag)
`ifdef TWOS_MIN_FLAG_EN
        ,
        .out_min   (out_min)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: sign is the MSB, magnitude is 2^W - x for negatives (mod 2^W).
    function automatic void model(input logic [W-1:0] x, output logic s, output logic [W-1:0] m);
        int v;
        v = int'(x);
        s = x[W-1];
        m = s ? W'(((1 << W) - v) % (1 << W)) : x;
    endfunction

    task automatic run(input logic [W-1:0] x, input int hold);
        int           lat;
        logic         es;
        logic [W-1:0] em;
        model(x, es, em);
        @(negedge clk);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        check("busy_rdy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, W);
        check("sign", out_sign, es);
        check("mag", out_mag, em);
`ifdef TWOS_MIN_FLAG_EN
        check("min", out_min, (x == {1'b1, {(W-1){1'b0}}}));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_sign", out_sign, es);
            check("hold_mag", out_mag, em);
            check("hold_rdy", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ack_valid", out_valid, 0);
        check("ack_rdy", in_ready, 1);
        check("kept_mag", out_mag, em);
        check("kept_sign", out_sign, es);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_sign"}, out_sign, 0);
        check({tag, "_mag"}, out_mag, 0);
        check({tag, "_rdy"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        check_reset_state("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run(4'b0101, 0);
        run(4'b1011, 0);
        run(4'b1111, 0);
        run(4'b1000, 0);
        run(4'b1001, 0);
        run(4'b0000, 0);
        run(4'b0110, 3);

        // Reset while holding a result in DONE
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'b1011;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_reached", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_done");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Reset after two shift cycles of a negative word
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1110;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_shift");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_valid", out_valid, 0);
        end

        for (int x = 0; x < (1 << W); x++) begin
            run(W'(x), 0);
        end

        for (int i = 0; i < 30; i++) begin
            run(W'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
